doorlock_input_cond: RTL and testbench
======================================

# doorlock_input_cond

Input conditioning stage directly upstream of the doorlock password FSM. It synchronises and debounces the raw switch bank and the two push-buttons. It presents clean switch levels, plus one-cycle rising-edge pulses for the start and end buttons. All downstream logic sees only glitch-free, clock-aligned signals.

## Interface
Parameters:
- `DB_CYCLES`, default 500000: consecutive stable cycles required before accepting a new level (10 ms at 50 MHz). Legal range is 2 or more.
- `SW_W`, default 8: width of the switch bank.

Ports:
- `clk` in 1: the single system clock.
- `rst` in 1: the reset is synchronous and active-high.
- `sw_raw` in SW_W: asynchronous slide-switch inputs.
- `btn_start_raw` in 1: asynchronous start button, active-high.
- `btn_end_raw` in 1: asynchronous end button, active-high.
- `sw` out SW_W: debounced switch levels.
- `sw_rise` out SW_W: one-cycle pulse per bit on a debounced 0→1 transition.
- `btn_start` out 1: one-cycle pulse on a debounced press of start.
- `btn_end` out 1: one-cycle pulse on a debounced press of end.
- `btn_start_lvl`, `btn_end_lvl` out 1 each: debounced button levels.

## Operation
- There are SW_W+2 identical, independent channels: one per switch bit, one per button.
- Each channel starts with a 2-flop synchroniser, `s1` then `s2`, both reset to 0.
- Each channel keeps a stable register `lvl`, reset to 0.
- Each channel has a counter `cnt`, `$clog2(DB_CYCLES)` bits wide, reset to 0.
- Each channel has a state machine with states `ST_STABLE` and `ST_COUNT`; the reset state is `ST_STABLE`.
- Transitions from `ST_STABLE`:
  - If `s2 != lvl`, go to `ST_COUNT` with `cnt <= 1`.
  - Otherwise stay, with `cnt <= 0`.
- Transitions from `ST_COUNT`:
  - If `s2 == lvl` (bounce), go to `ST_STABLE` with `cnt <= 0`. No output change.
  - Otherwise, if `cnt == DB_CYCLES-1`, go to `ST_STABLE`: `lvl <= s2`, `cnt <= 0`, and set the `rise` flag if `s2 == 1`.
  - Otherwise, `cnt <= cnt+1`.
- `rise` is a registered pulse, high for exactly the one cycle after `lvl` transitions 0→1. A 1→0 transition generates no pulse.
- `sw` and `sw_rise` come directly from the switch channels.
- `btn_start` and `btn_end` are the button channels' `rise` outputs.
- `*_lvl` outputs are the button channels' `lvl` registers.
- Simultaneous presses of both buttons, or several switches: each channel behaves independently, and both pulses may be high in the same cycle. Priority is resolved downstream.
- A held button yields one pulse only; a new pulse requires a debounced release and then a new press.
- Reset asserted mid-count:
  - All channels return to `ST_STABLE`, with `cnt`, `lvl`, `s1` and `s2` cleared.
  - All outputs read 0 on the cycle after the reset edge.
- An input already high at reset release is treated as a fresh press. It produces a `lvl` rise and one pulse after the standard latency.

## Timing
- All outputs are registered and reset to 0.
- Latency: let the raw input change and stay stable before clock edge k.
  - `s2` reflects the change after edge k+1.
  - `lvl` and the pulse update after edge k+1+DB_CYCLES.
  - Total latency is DB_CYCLES+2 edges.
- Pulse width is exactly 1 cycle.
- A bounce shorter than DB_CYCLES cycles at `s2` never changes `lvl`.
- Counter width must hold DB_CYCLES-1; the counter never wraps because it is cleared on accept or on bounce.

## Structure
- A shared package, `doorlock_pkg`, holds:
  - The `ch_state_t` enum (`ST_STABLE`, `ST_COUNT`).
  - The `DB_CYCLES_DEF` = 500000 constant.
  - The `SW_W_DEF` = 8 constant.
- Sub-module `debounce_ch`, parameterised by DB_CYCLES, contains one channel: the synchroniser, FSM, counter, `lvl` and `rise`.
- The top level instantiates it SW_W+2 times with a generate loop and does only the output wiring.

## Test plan
Run the bench with DB_CYCLES=4.
- Reset behaviour: assert `rst` with all raw inputs high → all outputs are 0 on the cycle after the reset edge. Release reset with inputs still high → `btn_start` pulse and `sw`=8'hFF after 6 edges.
- Clean press: `btn_start_raw` goes 0→1 before edge k and is held → `btn_start` is high only in the cycle after edge k+5, and `btn_start_lvl` is 1 from then on. Holding for 100 cycles gives no further pulses.
- Bounce rejection: `sw_raw[0]` toggles 1,0,1,0 with 2-cycle high periods, then returns to 0 → `sw[0]` stays 0 and `sw_rise` stays 0.
- Switch bank: `sw_raw` goes 8'h00→8'h45 → after 6 edges, `sw`=8'h45 and `sw_rise`=8'h45 for 1 cycle. Then `sw_raw`=8'h00 → `sw`=8'h00 after 6 edges with no `sw_rise`.
- Simultaneous buttons: both raw buttons rise in the same cycle → `btn_start` and `btn_end` pulse in the same cycle.
- Reset mid-count: `btn_end_raw` rises, and `rst` pulses at edge k+3 → no pulse before reset. With the input held, a pulse appears 6 edges after reset release.

Source files
------------

// File: rtl/doorlock_pkg.sv
// Shared types and defaults for the doorlock input conditioning stage.
package doorlock_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } ch_state_t;

    localparam int DB_CYCLES_DEF = 500000;
    localparam int SW_W_DEF      = 8;

endpackage

// File: rtl/debounce_ch.sv
// One conditioning channel: 2-flop synchroniser, debounce FSM with stability
// counter, accepted level register and a one-cycle rising-edge pulse.
module debounce_ch
    import doorlock_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic rise
);

    localparam int              CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    ch_state_t        state;
    ch_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lvl_nxt;
    logic             rise_nxt;

    // Bring the asynchronous input into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // State, counter, accepted level and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_STABLE;
            cnt   <= '0;
            lvl   <= 1'b0;
            rise  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lvl   <= lvl_nxt;
            rise  <= rise_nxt;
        end
    end

    // Next-state logic: a new level is accepted only after it has been seen
    // for DB_CYCLES consecutive cycles; any return to the old level restarts.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        lvl_nxt   = lvl;
        rise_nxt  = 1'b0;
        unique case (state)
            ST_STABLE: begin
                if (s2 != lvl) begin
                    state_nxt = ST_COUNT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_COUNT: begin
                if (s2 == lvl) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ST_STABLE;
                    lvl_nxt   = s2;
                    rise_nxt  = s2;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_STABLE;
            end
        endcase
    end

endmodule

// File: rtl/doorlock_input_cond.sv
// Input conditioning for the doorlock: debounces the switch bank and the
// start/end buttons with independent identical channels.
module doorlock_input_cond
    import doorlock_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int SW_W      = SW_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_raw,
    input  logic            btn_start_raw,
    input  logic            btn_end_raw,
    output logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] sw_rise,
    output logic            btn_start,
    output logic            btn_end,
    output logic            btn_start_lvl,
    output logic            btn_end_lvl
);

    localparam int N_CH = SW_W + 2;

    // Channel order: switches in the low bits, then start, then end.
    logic [N_CH-1:0] raw_all;
    logic [N_CH-1:0] lvl_all;
    logic [N_CH-1:0] rise_all;

    assign raw_all = {btn_end_raw, btn_start_raw, sw_raw};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .DB_CYCLES(DB_CYCLES)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .raw (raw_all[i]),
            .lvl (lvl_all[i]),
            .rise(rise_all[i])
        );
    end

    assign sw            = lvl_all[SW_W-1:0];
    assign sw_rise       = rise_all[SW_W-1:0];
    assign btn_start     = rise_all[SW_W];
    assign btn_end       = rise_all[SW_W+1];
    assign btn_start_lvl = lvl_all[SW_W];
    assign btn_end_lvl   = lvl_all[SW_W+1];

endmodule

// File: tb/tb_doorlock_input_cond.sv
// Bench for doorlock_input_cond with DB_CYCLES=4: table-driven vectors for
// switch bank, bounce and simultaneous buttons, plus hand-written sequences
// for reset, clean press with long hold, and reset mid-count.
module tb_doorlock_input_cond;

    localparam int DB = 4;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic         btn_start_raw = 1'b0;
    logic         btn_end_raw = 1'b0;
    logic [W-1:0] sw;
    logic [W-1:0] sw_rise;
    logic         btn_start;
    logic         btn_end;
    logic         btn_start_lvl;
    logic         btn_end_lvl;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] sw_raw;
        logic         bs;
        logic         be;
        logic [W-1:0] e_sw;
        logic [W-1:0] e_rise;
        logic         e_bs;
        logic         e_be;
        logic         e_bsl;
        logic         e_bel;
    } vec_t;

    vec_t vecs[$];

    doorlock_input_cond #(
        .DB_CYCLES(DB),
        .SW_W     (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_raw       (sw_raw),
        .btn_start_raw(btn_start_raw),
        .btn_end_raw  (btn_end_raw),
        .sw           (sw),
        .sw_rise      (sw_rise),
        .btn_start    (btn_start),
        .btn_end      (btn_end),
        .btn_start_lvl(btn_start_lvl),
        .btn_end_lvl  (btn_end_lvl)
    );

    always #5 clk = ~clk;

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {12'd0, sw, sw_rise, btn_start, btn_end, btn_start_lvl, btn_end_lvl};
    endfunction

    function automatic logic [31:0] pack_exp(input vec_t v);
        return {12'd0, v.e_sw, v.e_rise, v.e_bs, v.e_be, v.e_bsl, v.e_bel};
    endfunction

    task automatic add(input logic [W-1:0] r, input logic bs, input logic be,
                       input logic [W-1:0] esw, input logic [W-1:0] eri,
                       input logic ebs, input logic ebe, input logic ebsl, input logic ebel);
        vec_t v;
        v.sw_raw = r;   v.bs = bs;     v.be = be;
        v.e_sw = esw;   v.e_rise = eri;
        v.e_bs = ebs;   v.e_be = ebe;  v.e_bsl = ebsl; v.e_bel = ebel;
        vecs.push_back(v);
    endtask

    task automatic settle_low();
        sw_raw = '0; btn_start_raw = 1'b0; btn_end_raw = 1'b0;
        repeat (DB + 4) tick();
    endtask

    initial begin
        int pulses;

        // Switch bank 00 -> 45 -> 00.
        for (int i = 0; i < 5; i++) add(8'h45, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(8'h45, 0, 0, 8'h45, 8'h45, 0, 0, 0, 0);
        add(8'h45, 0, 0, 8'h45, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(8'h00, 0, 0, 8'h45, 8'h00, 0, 0, 0, 0);
        add(8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        // Bounce on sw_raw[0]: 1,1,0,0,1,1 then 0; must never be accepted.
        add(8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        // Both buttons pressed together, then released together.
        for (int i = 0; i < 5; i++) add(8'h00, 1, 1, 8'h00, 8'h00, 0, 0, 0, 0);
        add(8'h00, 1, 1, 8'h00, 8'h00, 1, 1, 1, 1);
        add(8'h00, 1, 1, 8'h00, 8'h00, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) add(8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1);
        add(8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

        // Reset state.
        rst = 1'b1;
        tick();
        check("reset_state", outs(), 32'd0);

        // Reset with all inputs high, then release with inputs still high.
        sw_raw = 8'hFF; btn_start_raw = 1'b1; btn_end_raw = 1'b1;
        tick();
        check("reset_inputs_high", outs(), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("release_wait", outs(), 32'd0);
        end
        tick();
        check("release_accept", outs(), {12'd0, 8'hFF, 8'hFF, 4'b1111});
        tick();
        check("release_after", outs(), {12'd0, 8'hFF, 8'h00, 4'b0011});
        settle_low();
        check("release_settled", outs(), 32'd0);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            sw_raw        = vecs[i].sw_raw;
            btn_start_raw = vecs[i].bs;
            btn_end_raw   = vecs[i].be;
            tick();
            check($sformatf("vec%0d", i), outs(), pack_exp(vecs[i]));
        end

        // Clean press of start, held for 100 cycles: exactly one pulse.
        btn_start_raw = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            pulses += int'(btn_start);
        end
        check("press_no_early_pulse", 32'(pulses), 32'd0);
        tick();
        check("press_pulse", {30'd0, btn_start, btn_start_lvl}, 32'b11);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            pulses += int'(btn_start);
        end
        check("hold_no_repulse", 32'(pulses), 32'd0);
        check("hold_lvl", {31'd0, btn_start_lvl}, 32'd1);

        // Reset while a level is held clears it immediately.
        btn_start_raw = 1'b0;
        rst = 1'b1;
        tick();
        check("reset_clears_lvl", outs(), 32'd0);
        rst = 1'b0;
        settle_low();
        check("after_reset_settled", outs(), 32'd0);

        // Reset mid-count on end button: no pulse before, one pulse 6 edges after release.
        btn_end_raw = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(btn_end);
        end
        rst = 1'b1;
        tick();
        pulses += int'(btn_end);
        check("midcount_no_pulse", 32'(pulses), 32'd0);
        check("midcount_reset_outs", outs(), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            pulses += int'(btn_end);
        end
        check("midcount_wait", 32'(pulses), 32'd0);
        tick();
        check("midcount_pulse", {30'd0, btn_end, btn_end_lvl}, 32'b11);
        tick();
        check("midcount_pulse_width", {30'd0, btn_end, btn_end_lvl}, 32'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
